// File: rtl/camera_tx_if.sv
// Pixel-stream and parallel-camera signal bundle for camera_tx.
// master: the camera_tx side (takes pixels, drives the camera bus).
// slave : the pixel source / camera receiver side.
interface camera_tx_if;
   logic [15:0] pixel_data_in;     // RGB565 pixel from upstream
   logic        pixel_valid_in;    // pixel_data_in valid
   logic        pixel_ready_out;   // pixel consumed this cycle
   logic [10:0] pixel_hcount_out;  // column of requested pixel
   logic [9:0]  pixel_vcount_out;  // row of requested pixel
   logic        cam_pclk;
   logic        cam_hsync;
   logic        cam_vsync;
   logic [7:0]  camera_d;

   modport master (
      input  pixel_data_in, pixel_valid_in,
      output pixel_ready_out, pixel_hcount_out, pixel_vcount_out,
      output cam_pclk, cam_hsync, cam_vsync, camera_d
   );

   modport slave (
      output pixel_data_in, pixel_valid_in,
      input  pixel_ready_out, pixel_hcount_out, pixel_vcount_out,
      input  cam_pclk, cam_hsync, cam_vsync, camera_d
   );
endinterface

// File: rtl/camera_tx.sv
// Parallel camera transmitter: streams RGB565 pixels as byte pairs with hsync/vsync framing.
// Latency: a pixel is on camera_d (high byte) from the clk_in edge that accepts it.
// Backpressure: none toward the camera; a missing pixel is sent as 0x0000 and flags underflow.
// Ports: clk_in/rst_in (async active-low), enable_in (start/continue frames),
//        bus (camera_tx_if.master: pixel request/accept + camera bus), underflow_out (sticky).
module camera_tx #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int H_BLANK  = 64,
   parameter int V_BLANK  = 8,
   parameter int V_SYNC   = 2,
   parameter int CLK_DIV  = 2
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         enable_in,
   camera_tx_if.master  bus,
   output logic         underflow_out
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_HBLANK = 2'd2;
   localparam logic [1:0] S_VBLANK = 2'd3;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
   localparam logic [9:0]  VB_LAST  = 10'(V_BLANK - 1);
   localparam logic [9:0]  VS_LINES = 10'(V_SYNC);
   localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
   // A vertical-blank line lasts as long as a full active line plus its blank.
   localparam logic [15:0] VL_LAST  = 16'(2 * H_ACTIVE + H_BLANK - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] div_q, div_d;
   logic        pclk_q, pclk_d;
   logic [10:0] pix_q, pix_d;       // pixel column on the bus
   logic        phase_q, phase_d;   // 0: high byte on the bus, 1: low byte
   logic [9:0]  line_q, line_d;     // active line, or blank line in VBLANK
   logic [15:0] blk_q, blk_d;       // pclk period within a blank interval
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic [7:0]  dat_q, dat_d;
   logic [7:0]  lo_q, lo_d;         // low byte held for the second half of the pixel
   logic        underflow_q, underflow_d;
   logic        fall_tick;
   logic        launch_hi;

   // Every output change is aligned with the pclk 1->0 transition.
   assign fall_tick = (div_q == DIV_LAST) && pclk_q;

   always_comb begin
      div_d       = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
      pclk_d      = (div_q == DIV_LAST) ? ~pclk_q : pclk_q;
      state_d     = state_q;
      pix_d       = pix_q;
      phase_d     = phase_q;
      line_d      = line_q;
      blk_d       = blk_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      dat_d       = dat_q;
      lo_d        = lo_q;
      launch_hi   = 1'b0;

      if (fall_tick) begin
         case (state_q)
            S_IDLE: begin
               if (enable_in) begin
                  state_d   = S_ACTIVE;
                  pix_d     = 11'd0;
                  phase_d   = 1'b0;
                  line_d    = 10'd0;
                  launch_hi = 1'b1;
               end
            end
            S_ACTIVE: begin
               if (!phase_q) begin
                  phase_d = 1'b1;
                  dat_d   = lo_q;
               end else if (pix_q == H_LAST) begin
                  state_d = S_HBLANK;
                  blk_d   = 16'd0;
                  hsync_d = 1'b0;
                  dat_d   = 8'd0;
               end else begin
                  pix_d     = pix_q + 11'd1;
                  phase_d   = 1'b0;
                  launch_hi = 1'b1;
               end
            end
            S_HBLANK: begin
               if (blk_q != HB_LAST) begin
                  blk_d = blk_q + 16'd1;
               end else if (line_q != V_LAST) begin
                  state_d   = S_ACTIVE;
                  line_d    = line_q + 10'd1;
                  pix_d     = 11'd0;
                  phase_d   = 1'b0;
                  launch_hi = 1'b1;
               end else begin
                  state_d = S_VBLANK;
                  line_d  = 10'd0;
                  blk_d   = 16'd0;
                  vsync_d = (VS_LINES != 10'd0);
               end
            end
            default: begin // S_VBLANK
               if (blk_q != VL_LAST) begin
                  blk_d = blk_q + 16'd1;
               end else if (line_q != VB_LAST) begin
                  line_d  = line_q + 10'd1;
                  blk_d   = 16'd0;
                  vsync_d = ((line_q + 10'd1) < VS_LINES);
               end else begin
                  // End of frame: enable_in is only sampled here, so frames never truncate.
                  vsync_d = 1'b0;
                  blk_d   = 16'd0;
                  line_d  = 10'd0;
                  if (enable_in) begin
                     state_d   = S_ACTIVE;
                     pix_d     = 11'd0;
                     phase_d   = 1'b0;
                     launch_hi = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         endcase

         // A starved pixel goes out as two zero bytes.
         if (launch_hi) begin
            hsync_d = 1'b1;
            dat_d   = bus.pixel_valid_in ? bus.pixel_data_in[15:8] : 8'd0;
            lo_d    = bus.pixel_valid_in ? bus.pixel_data_in[7:0]  : 8'd0;
         end
      end

      underflow_d = underflow_q | (launch_hi & ~bus.pixel_valid_in);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= S_IDLE;
         div_q       <= 16'd0;
         pclk_q      <= 1'b0;
         pix_q       <= 11'd0;
         phase_q     <= 1'b0;
         line_q      <= 10'd0;
         blk_q       <= 16'd0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         dat_q       <= 8'd0;
         lo_q        <= 8'd0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         pclk_q      <= pclk_d;
         pix_q       <= pix_d;
         phase_q     <= phase_d;
         line_q      <= line_d;
         blk_q       <= blk_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         dat_q       <= dat_d;
         lo_q        <= lo_d;
         underflow_q <= underflow_d;
      end
   end

   // Request strobe and coordinates come straight from the launch decision so the
   // source sees them in the same cycle the high byte is captured.
   assign bus.pixel_ready_out  = launch_hi;
   assign bus.pixel_hcount_out = launch_hi ? pix_d  : 11'd0;
   assign bus.pixel_vcount_out = launch_hi ? line_d : 10'd0;
   assign bus.cam_pclk         = pclk_q;
   assign bus.cam_hsync        = hsync_q;
   assign bus.cam_vsync        = vsync_q;
   assign bus.camera_d         = dat_q;
   assign underflow_out        = underflow_q;

endmodule

// File: tb/tb_camera_tx.sv
// Directed bench for camera_tx with a tiny frame (4x2 active, 11-pclk lines, 55-pclk frames).
module tb_camera_tx;
   localparam int HA  = 4;
   localparam int VA  = 2;
   localparam int HB  = 3;
   localparam int VB  = 3;
   localparam int VS  = 1;
   localparam int DIV = 2;
   localparam int LINE  = 2 * HA + HB;        // 11
   localparam int FRAME = LINE * (VA + VB);   // 55

   logic clk_in;
   logic rst_in;
   logic enable_in;
   logic underflow_out;

   camera_tx_if bus();

   camera_tx #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
      .V_BLANK(VB), .V_SYNC(VS), .CLK_DIV(DIV)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .enable_in     (enable_in),
      .bus           (bus),
      .underflow_out (underflow_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] rise_d[$];
   logic       rise_hs[$];
   logic       rise_vs[$];
   int         rdy_h[$];
   int         rdy_v[$];
   int         pulse_k;
   int         drop_k;
   logic       last_rdy;
   logic       prev_pclk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Pixel k of the run carries 0xAB, k+1; pulse drop_k is withheld.
   task automatic drive_pixel();
      bus.pixel_data_in  = {8'hAB, 8'(pulse_k + 1)};
      bus.pixel_valid_in = (pulse_k != drop_k);
   endtask

   // One clk_in cycle: sample 1 ns after the rising edge, log pclk rises and requests.
   task automatic tick();
      @(posedge clk_in);
      #1;
      if (last_rdy) begin
         pulse_k++;
         drive_pixel();
      end
      last_rdy = bus.pixel_ready_out;
      if (last_rdy) begin
         rdy_h.push_back(int'(bus.pixel_hcount_out));
         rdy_v.push_back(int'(bus.pixel_vcount_out));
      end
      if (bus.cam_pclk && !prev_pclk) begin
         rise_d.push_back(bus.camera_d);
         rise_hs.push_back(bus.cam_hsync);
         rise_vs.push_back(bus.cam_vsync);
      end
      prev_pclk = bus.cam_pclk;
   endtask

   task automatic run_rises(input int n, input string tag);
      int budget = 3000;
      while (rise_d.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      check(tag, 32'(rise_d.size() >= n), 32'd1);
   endtask

   // Expected bus at frame period p_abs (counted from the first frame start).
   task automatic exp_rise(input int p_abs, input int nframes,
                           output logic [7:0] d, output logic hs, output logic vs);
      int f, p, ln, col, k;
      f   = p_abs / FRAME;
      p   = p_abs % FRAME;
      ln  = p / LINE;
      col = p % LINE;
      d = 8'h00; hs = 1'b0; vs = 1'b0;
      if (f < nframes) begin
         hs = (ln < VA) && (col < 2 * HA);
         vs = (p >= VA * LINE) && (p < (VA + VS) * LINE);
         if (hs) begin
            k = f * HA * VA + ln * HA + col / 2;
            if (k == drop_k)       d = 8'h00;
            else if (col % 2 == 0) d = 8'hAB;
            else                   d = 8'(k + 1);
         end
      end
   endtask

   task automatic check_rises(input int last, input int nframes);
      logic [7:0] d;
      logic hs, vs;
      int top;
      top = (rise_d.size() - 1 < last) ? rise_d.size() - 1 : last;
      for (int r = 1; r <= top; r++) begin
         exp_rise(r - 1, nframes, d, hs, vs);
         check($sformatf("byte[%0d]", r),  32'(rise_d[r]),  32'(d));
         check($sformatf("hsync[%0d]", r), 32'(rise_hs[r]), 32'(hs));
         check($sformatf("vsync[%0d]", r), 32'(rise_vs[r]), 32'(vs));
      end
   endtask

   task automatic check_ready(input int n);
      int top;
      top = (rdy_h.size() < n) ? rdy_h.size() : n;
      for (int i = 0; i < top; i++) begin
         check($sformatf("req_h[%0d]", i), 32'(rdy_h[i]), 32'(i % HA));
         check($sformatf("req_v[%0d]", i), 32'(rdy_v[i]), 32'((i / HA) % VA));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pclk"},  32'(bus.cam_pclk),        32'd0);
      check({tag, "_hsync"}, 32'(bus.cam_hsync),       32'd0);
      check({tag, "_vsync"}, 32'(bus.cam_vsync),       32'd0);
      check({tag, "_d"},     32'(bus.camera_d),        32'd0);
      check({tag, "_ready"}, 32'(bus.pixel_ready_out), 32'd0);
      check({tag, "_uflow"}, 32'(underflow_out),       32'd0);
   endtask

   initial begin
      int budget;
      rst_in    = 1'b0;
      enable_in = 1'b0;
      pulse_k   = 0;
      drop_k    = 18;          // pixel (2,0) of the third frame
      drive_pixel();
      last_rdy  = 1'b0;
      prev_pclk = 1'b0;

      repeat (3) @(posedge clk_in);
      #1;
      check_all_zero("reset");

      // Frames 0..2 back to back, then into frame 3.
      enable_in = 1'b1;
      rst_in    = 1'b1;
      tick();
      check("pclk_lat_1", 32'(bus.cam_pclk), 32'd0);
      tick();
      check("pclk_lat_2", 32'(bus.cam_pclk), 32'd1);

      run_rises(1 + 2 * FRAME, "wait_frames01");
      check("uflow_clean", 32'(underflow_out), 32'd0);

      run_rises(1 + 3 * FRAME + 3, "wait_frame3");
      check("uflow_sticky", 32'(underflow_out), 32'd1);
      check("mid_line_hsync", 32'(bus.cam_hsync), 32'd1);

      // Asynchronous reset between clock edges while a line is active.
      #2 rst_in = 1'b0;
      #1;
      check_all_zero("async_rst");

      check_rises(3 * FRAME + 3, 99);
      check("req_count_run1", 32'(rdy_h.size() >= 24), 32'd1);
      check_ready(24);

      // Restart; drop enable_in at pixel (1,0) and expect exactly one more frame.
      rise_d.delete(); rise_hs.delete(); rise_vs.delete();
      rdy_h.delete();  rdy_v.delete();
      pulse_k   = 0;
      drop_k    = -1;
      drive_pixel();
      last_rdy  = 1'b0;
      prev_pclk = 1'b0;
      #1 rst_in = 1'b1;
      tick();
      check("restart_lat_1", 32'(bus.cam_pclk), 32'd0);
      tick();
      check("restart_lat_2", 32'(bus.cam_pclk), 32'd1);

      budget = 200;
      while (rdy_h.size() < 2 && budget > 0) begin
         tick();
         budget--;
      end
      check("wait_pixel_1_0", 32'(rdy_h.size()), 32'd2);
      enable_in = 1'b0;

      run_rises(1 + FRAME + 16, "wait_idle");
      check_rises(FRAME + 16, 1);
      check("req_count_run2", 32'(rdy_h.size()), 32'(HA * VA));
      check_ready(HA * VA);
      check("uflow_after_rst", 32'(underflow_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/camera_tx.md
CAMERA_TX -- requirements
Module: camera_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 64, horizontal blank length in pclk periods.
REQ-004 SHALL have parameter V_BLANK, default 8, vertical blank length in lines; V_SYNC, default 2, vsync length in lines (V_SYNC <= V_BLANK).
REQ-005 SHALL have parameter CLK_DIV, default 2, clk_in cycles per pclk half-period (>= 1).
REQ-006 SHALL have clk_in  input  1  single clock for all logic.
REQ-007 SHALL have rst_in  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have enable_in  input  1  start/continue frames.
REQ-009 SHALL have pixel_data_in  input  16  RGB565 pixel from upstream.
REQ-010 SHALL have pixel_valid_in  input  1  pixel_data_in valid.
REQ-011 SHALL have pixel_ready_out  output  1  pixel consumed this cycle.
REQ-012 SHALL have pixel_hcount_out  output  11 and pixel_vcount_out  output  10, coordinates of the pixel requested, meaningful while pixel_ready_out=1.
REQ-013 SHALL have cam_pclk, cam_hsync, cam_vsync  output  1 each, and camera_d  output  8, parallel camera bus.
REQ-014 SHALL have underflow_out  output  1  sticky pixel-starvation flag.

Function
REQ-015 cam_pclk SHALL toggle every CLK_DIV clk_in cycles from reset release, never stopping, 50% duty.
REQ-016 camera_d, cam_hsync, cam_vsync SHALL change only in the clk_in cycle where cam_pclk goes 1->0, stable across the following rising edge.
REQ-017 Line = 2*H_ACTIVE byte periods with cam_hsync=1, then H_BLANK pclk periods with cam_hsync=0, camera_d=0.
REQ-018 Each pixel SHALL be sent as two bytes, pixel[15:8] first, then pixel[7:0].
REQ-019 Frame = V_ACTIVE active lines, then V_BLANK blank lines (cam_hsync=0 throughout), same line length.
REQ-020 cam_vsync SHALL be 1 for exactly the first V_SYNC blank lines of each frame, else 0.
REQ-021 FSM states IDLE, ACTIVE, HBLANK, VBLANK; IDLE->ACTIVE at first pclk falling edge with enable_in=1; ACTIVE->HBLANK after last byte; HBLANK->ACTIVE (more lines) or VBLANK (after line V_ACTIVE-1); VBLANK->ACTIVE if enable_in=1 at end of last blank line, else IDLE.
REQ-022 enable_in falling mid-frame SHALL NOT truncate the frame; block finishes through VBLANK then enters IDLE.
REQ-023 pixel_ready_out SHALL pulse for exactly one clk_in cycle: the cycle launching each pixel's high byte; pixel accepted iff pixel_valid_in=1 in that cycle.
REQ-024 pixel_hcount_out/pixel_vcount_out SHALL equal the pixel's 0-based column/row; hcount wraps to 0 each line, vcount to 0 each frame.
REQ-025 If pixel_valid_in=0 at a ready pulse, both bytes of that pixel SHALL be 0x00 and underflow_out SHALL set to 1, held until reset.
REQ-026 In IDLE: cam_hsync=0, cam_vsync=0, camera_d=0, pixel_ready_out=0.

Reset
REQ-027 rst_in=0 SHALL immediately force cam_pclk=0, cam_hsync=0, cam_vsync=0, camera_d=0, pixel_ready_out=0, underflow_out=0, counters 0, state IDLE, including mid-line/mid-frame.
REQ-028 After rst_in deasserts, first cam_pclk rising edge SHALL occur CLK_DIV clk_in cycles later.

Verification (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, V_BLANK=3, V_SYNC=1, CLK_DIV=2; line=11 pclk, frame=55 pclk)
REQ-029 Reset then enable_in=1, pixel_valid_in=1, pixels 0xAB01,0xAB02,...: rising-edge bytes AB,01,AB,02,...; cam_hsync=1 for 8 pclk, 0 for 3.
REQ-030 Full frame: exactly 8 ready pulses, (h,v)=(0,0)..(3,1) in order; cam_vsync=1 for pclk periods 22-32 of frame, 0 elsewhere.
REQ-031 pixel_valid_in=0 at request (2,0) only -> bytes 00,00 for that pixel, underflow_out=1 and stays 1 through next frame.
REQ-032 enable_in dropped at pixel (1,0) -> frame completes all 55 pclk periods, then IDLE, no further ready pulses; cam_pclk keeps toggling.
REQ-033 rst_in=0 mid active line (cam_hsync=1) -> all outputs 0 in same cycle, no clock edge required; restart produces frame from (0,0).
REQ-034 enable_in held 1 across frames -> second frame's first high byte follows last blank pclk period with zero gap.
